// File: rtl/mem_wb_skid_stage_if.sv
// ----------------------------------------------------------------------------
// mem_wb_skid_stage_if
// Handshake and payload bundle for the MEM->WB stage register.
//   Upstream (MEM side)  : in_valid / in_ready plus the beat fields *_in
//   Downstream (WB side) : out_valid / out_ready plus the head-beat fields *_out
//   Forwarding taps      : fwd_valid / fwd_reg / fwd_data, present only when
//                          MEMWB_FWD_EN is defined
// Modports:
//   slave  - the stage itself: consumes *_in and out_ready, drives the rest
//   master - the surrounding pipeline (MEM source plus WB sink)
// ----------------------------------------------------------------------------
interface mem_wb_skid_stage_if #(
  parameter int B  = 32,
  parameter int RA = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [B-1:0]  read_data_in;
  logic [B-1:0]  alu_result_in;
  logic [RA-1:0] reg_dst_in;
  logic          wb_RegWrite_in;
  logic          wb_MemtoReg_in;

  logic          out_valid;
  logic          out_ready;
  logic [B-1:0]  read_data_out;
  logic [B-1:0]  alu_result_out;
  logic [RA-1:0] reg_dst_out;
  logic          wb_RegWrite_out;
  logic          wb_MemtoReg_out;

`ifdef MEMWB_FWD_EN
  logic          fwd_valid;
  logic [RA-1:0] fwd_reg;
  logic [B-1:0]  fwd_data;
`endif

  modport slave (
    input  in_valid, read_data_in, alu_result_in, reg_dst_in,
           wb_RegWrite_in, wb_MemtoReg_in, out_ready,
    output in_ready, out_valid, read_data_out, alu_result_out, reg_dst_out,
           wb_RegWrite_out, wb_MemtoReg_out
`ifdef MEMWB_FWD_EN
    , output fwd_valid, fwd_reg, fwd_data
`endif
  );

  modport master (
    output in_valid, read_data_in, alu_result_in, reg_dst_in,
           wb_RegWrite_in, wb_MemtoReg_in, out_ready,
    input  in_ready, out_valid, read_data_out, alu_result_out, reg_dst_out,
           wb_RegWrite_out, wb_MemtoReg_out
`ifdef MEMWB_FWD_EN
    , input fwd_valid, fwd_reg, fwd_data
`endif
  );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_skid_stage
// MEM->WB pipeline register with a valid/ready handshake and a 2-entry skid
// buffer (main entry = head, skid entry = overflow). WB back-pressure stalls
// MEM without losing or duplicating beats; flush squashes everything held.
// Control bits of a non-valid head are forced to 0 so a bubble never writes
// the register file.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (clears valid bits and all fields)
//   flush  - synchronous squash of all held beats; same-cycle accept dropped
//   bus    - mem_wb_skid_stage_if.slave (handshakes, payload, forwarding)
// Optional feature: define MEMWB_FWD_EN to add the fwd_valid/fwd_reg/fwd_data
// taps that expose the head entry to the forwarding unit.
// ----------------------------------------------------------------------------
module mem_wb_skid_stage #(
  parameter int B  = 32,
  parameter int RA = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  mem_wb_skid_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [B-1:0]  rd;
    logic [B-1:0]  alu;
    logic [RA-1:0] dst;
    logic          rw;
    logic          m2r;
  } beat_t;

  state_e state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  beat_t  in_beat;
  logic   main_valid, skid_valid;
  logic   accept, pop;

  // Valid bits are encoded by the state: skid can never be valid alone.
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  // in_ready depends only on registered state, so out_ready never reaches it.
  assign bus.in_ready = !skid_valid;
  assign accept       = bus.in_valid & !skid_valid;
  assign pop          = main_valid & bus.out_ready;

  assign in_beat = '{rd:  bus.read_data_in,
                     alu: bus.alu_result_in,
                     dst: bus.reg_dst_in,
                     rw:  bus.wb_RegWrite_in,
                     m2r: bus.wb_MemtoReg_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Data registers keep their last value; only validity is squashed.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_beat;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_beat;
          end else if (accept) begin
            skid_d  = in_beat;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign bus.out_valid       = main_valid;
  assign bus.read_data_out   = main_q.rd;
  assign bus.alu_result_out  = main_q.alu;
  assign bus.reg_dst_out     = main_q.dst;
  assign bus.wb_RegWrite_out = main_q.rw  & main_valid;
  assign bus.wb_MemtoReg_out = main_q.m2r & main_valid;

`ifdef MEMWB_FWD_EN
  // x0 is hard-wired zero, so a write to it is never a forwarding source.
  assign bus.fwd_valid = main_valid & main_q.rw & (main_q.dst != '0);
  assign bus.fwd_reg   = main_q.dst;
  assign bus.fwd_data  = main_q.m2r ? main_q.rd : main_q.alu;
`endif

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
module tb_mem_wb_skid_stage;
  localparam int B  = 32;
  localparam int RA = 5;

  typedef struct packed {
    logic [B-1:0]  rd;
    logic [B-1:0]  alu;
    logic [RA-1:0] dst;
    logic          rw;
    logic          m2r;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  mem_wb_skid_stage_if #(.B(B), .RA(RA)) bus ();
  mem_wb_skid_stage #(.B(B), .RA(RA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  // Reference model: the stage is a FIFO of capacity 2 whose head is visible.
  beat_t mq[$];
  logic [B-1:0] pop_log[$];
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [B-1:0] rd, input logic [B-1:0] alu,
                               input logic [RA-1:0] dst, input logic rw, input logic m2r);
    beat_t b;
    b.rd = rd; b.alu = alu; b.dst = dst; b.rw = rw; b.m2r = m2r;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    return mk($urandom, $urandom, RA'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  task automatic check_model();
    beat_t h;
    check_eq("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    check_eq("in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
    if (mq.size() > 0) begin
      h = mq[0];
      check_eq("read_data_out", 64'(bus.read_data_out), 64'(h.rd));
      check_eq("alu_result_out", 64'(bus.alu_result_out), 64'(h.alu));
      check_eq("reg_dst_out", 64'(bus.reg_dst_out), 64'(h.dst));
      check_eq("wb_RegWrite_out", 64'(bus.wb_RegWrite_out), 64'(h.rw));
      check_eq("wb_MemtoReg_out", 64'(bus.wb_MemtoReg_out), 64'(h.m2r));
    end else begin
      check_eq("wb_RegWrite_idle", 64'(bus.wb_RegWrite_out), 64'd0);
      check_eq("wb_MemtoReg_idle", 64'(bus.wb_MemtoReg_out), 64'd0);
    end
`ifdef MEMWB_FWD_EN
    if (mq.size() > 0) begin
      h = mq[0];
      check_eq("fwd_valid", 64'(bus.fwd_valid), 64'(h.rw && (h.dst != 0)));
      check_eq("fwd_reg", 64'(bus.fwd_reg), 64'(h.dst));
      check_eq("fwd_data", 64'(bus.fwd_data), 64'(h.m2r ? h.rd : h.alu));
    end else begin
      check_eq("fwd_valid_idle", 64'(bus.fwd_valid), 64'd0);
    end
`endif
  endtask

  // Called just after a falling edge: check, drive, advance the model, clock.
  task automatic step(input logic iv, input beat_t b, input logic ordy, input logic fl,
                      output logic acc);
    logic pp;
    check_model();
    bus.in_valid       = iv;
    bus.read_data_in   = b.rd;
    bus.alu_result_in  = b.alu;
    bus.reg_dst_in     = b.dst;
    bus.wb_RegWrite_in = b.rw;
    bus.wb_MemtoReg_in = b.m2r;
    bus.out_ready      = ordy;
    flush              = fl;
    acc = iv && (mq.size() < 2);
    pp  = ordy && (mq.size() > 0);
    if (pp) pop_log.push_back(bus.alu_result_out);
    if (fl) begin
      mq.delete();
      acc = 1'b0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, '0, ordy, 1'b0, a);
  endtask

  initial begin
    logic  a;
    beat_t bb;
    int    n;
    bus.in_valid = 0; bus.read_data_in = 0; bus.alu_result_in = 0; bus.reg_dst_in = 0;
    bus.wb_RegWrite_in = 0; bus.wb_MemtoReg_in = 0; bus.out_ready = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_rw", 64'(bus.wb_RegWrite_out), 64'd0);
    check_eq("rst_alu", 64'(bus.alu_result_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming: 8 back-to-back beats, WB always ready
    pop_log.delete();
    for (int i = 1; i <= 8; i++) step(1'b1, mk(32'h100 + i, i, RA'(i), 1'b1, 1'b0), 1'b1, 1'b0, a);
    idle(1'b1); idle(1'b1);
    check_eq("stream_count", 64'(pop_log.size()), 64'd8);
    for (int i = 0; i < pop_log.size(); i++) check_eq("stream_order", 64'(pop_log[i]), 64'(i + 1));

    // Skid: A and B fill the stage, C is held by the source until accepted
    pop_log.delete();
    step(1'b1, mk(0, 32'hA, 5'd1, 1'b1, 1'b0), 1'b0, 1'b0, a);
    step(1'b1, mk(0, 32'hB, 5'd2, 1'b1, 1'b0), 1'b0, 1'b0, a);
    check_eq("skid_full_in_ready", 64'(bus.in_ready), 64'd0);
    step(1'b1, mk(0, 32'hC, 5'd3, 1'b1, 1'b0), 1'b0, 1'b0, a);
    step(1'b1, mk(0, 32'hC, 5'd3, 1'b1, 1'b0), 1'b0, 1'b0, a);
    n = 0;
    do begin
      step(1'b1, mk(0, 32'hC, 5'd3, 1'b1, 1'b0), 1'b1, 1'b0, a);
      n++;
    end while (!a && n < 6);
    check_eq("skid_c_accepted", 64'(a), 64'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_eq("skid_count", 64'(pop_log.size()), 64'd3);
    if (pop_log.size() == 3) begin
      check_eq("skid_A", 64'(pop_log[0]), 64'hA);
      check_eq("skid_B", 64'(pop_log[1]), 64'hB);
      check_eq("skid_C", 64'(pop_log[2]), 64'hC);
    end

    // Asynchronous reset while FULL
    step(1'b1, mk(32'h11, 32'h22, 5'd7, 1'b1, 1'b1), 1'b0, 1'b0, a);
    step(1'b1, mk(32'h33, 32'h44, 5'd8, 1'b1, 1'b0), 1'b0, 1'b0, a);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("arst_rw", 64'(bus.wb_RegWrite_out), 64'd0);
    check_eq("arst_m2r", 64'(bus.wb_MemtoReg_out), 64'd0);
    check_eq("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("arst_rd", 64'(bus.read_data_out), 64'd0);
    check_eq("arst_alu", 64'(bus.alu_result_out), 64'd0);
    check_eq("arst_dst", 64'(bus.reg_dst_out), 64'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Flush while FULL with RegWrite beats and a new beat offered
    step(1'b1, mk(1, 2, 5'd4, 1'b1, 1'b0), 1'b0, 1'b0, a);
    step(1'b1, mk(3, 4, 5'd5, 1'b1, 1'b0), 1'b0, 1'b0, a);
    step(1'b1, mk(5, 6, 5'd6, 1'b1, 1'b0), 1'b0, 1'b1, a);
    check_eq("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("flush_rw_gated", 64'(bus.wb_RegWrite_out), 64'd0);
    // Flush from ONE with a same-cycle accept: the new beat must be dropped
    step(1'b1, mk(7, 8, 5'd9, 1'b1, 1'b1), 1'b0, 1'b0, a);
    step(1'b1, mk(9, 10, 5'd10, 1'b1, 1'b1), 1'b0, 1'b1, a);
    check_eq("flush_one_out_valid", 64'(bus.out_valid), 64'd0);
    idle(1'b1); idle(1'b1);

    // Control gating: single RegWrite beat popped, stale fields remain in main
    step(1'b1, mk(32'h77, 32'h88, 5'd12, 1'b1, 1'b1), 1'b1, 1'b0, a);
    idle(1'b1);
    check_eq("gate_rw_empty", 64'(bus.wb_RegWrite_out), 64'd0);
    check_eq("gate_m2r_empty", 64'(bus.wb_MemtoReg_out), 64'd0);

`ifdef MEMWB_FWD_EN
    step(1'b1, mk(32'h55, 32'h99, 5'd3, 1'b1, 1'b1), 1'b0, 1'b0, a);
    check_eq("fwd_dir_valid", 64'(bus.fwd_valid), 64'd1);
    check_eq("fwd_dir_reg", 64'(bus.fwd_reg), 64'd3);
    check_eq("fwd_dir_data", 64'(bus.fwd_data), 64'h55);
    step(1'b1, mk(32'h55, 32'h99, 5'd0, 1'b1, 1'b1), 1'b1, 1'b0, a);
    check_eq("fwd_dir_x0", 64'(bus.fwd_valid), 64'd0);
    idle(1'b1); idle(1'b1);
`endif

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      bb = rnd_beat();
      step(1'($urandom_range(0, 99) < 60), bb, 1'($urandom_range(0, 99) < 65),
           1'($urandom_range(0, 99) < 4), a);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
